spi_tx_arbiter: RTL and testbench

- Shares the single SpiOut transmitter between two requesters: A (CPU I/O-write path) and B (autonomous source, e.g. tick-driven sampler).
- Each requester has a one-entry holding register with a valid/ready handshake.
- Pending words are granted round-robin. Each grant produces a one-cycle write strobe plus 16-bit word to SpiOut.
- The block then blocks further launches for a fixed frame time plus inter-frame gap, and reports completion with the source id.

---
 rtl/spi_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// Round-robin share of one SpiOut transmitter between requesters A and B, each behind a one-entry holding register.
// Accept to spi_write is 2 cycles; launches are spaced 1+FRAME_CYCLES+GAP_CYCLES apart; x_ready stays low while a word is held.
module spi_tx_arbiter #(
    parameter int WIDTH        = 16,
    parameter int FRAME_CYCLES = 18,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic [WIDTH-1:0] spi_data,
    output logic             spi_write,
    output logic             busy,
    output logic             done,
    output logic             done_src
);

    localparam int MAXC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             a_full;
    logic             b_full;
    logic [WIDTH-1:0] a_hold;
    logic [WIDTH-1:0] b_hold;
    logic             last_grant;
    logic             cur_src;
    logic             grant;
    logic             grant_b;
    logic             done_nxt;
    logic             a_accept;
    logic             b_accept;

    assign a_accept = a_valid & a_ready;
    assign b_accept = b_valid & b_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        grant_b   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (a_full | b_full) begin
                    grant     = 1'b1;
                    // B wins when alone, or on a tie when A was served last
                    grant_b   = b_full & (~a_full | ~last_grant);
                    cnt_nxt   = CW'(FRAME_CYCLES - 1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    done_nxt = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        cnt_nxt   = CW'(GAP_CYCLES - 1);
                        state_nxt = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ready lags the clearing grant by a cycle, so a slot is never refilled on its grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_full  <= 1'b0;
            b_full  <= 1'b0;
            a_ready <= 1'b1;
            b_ready <= 1'b1;
            a_hold  <= '0;
            b_hold  <= '0;
        end else begin
            if (a_accept) begin
                a_full  <= 1'b1;
                a_hold  <= a_data;
                a_ready <= 1'b0;
            end else begin
                if (grant & ~grant_b) begin
                    a_full <= 1'b0;
                end
                a_ready <= ~a_full;
            end
            if (b_accept) begin
                b_full  <= 1'b1;
                b_hold  <= b_data;
                b_ready <= 1'b0;
            end else begin
                if (grant & grant_b) begin
                    b_full <= 1'b0;
                end
                b_ready <= ~b_full;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_data   <= '0;
            spi_write  <= 1'b0;
            done       <= 1'b0;
            done_src   <= 1'b0;
            cur_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            spi_write <= grant;
            done      <= done_nxt;
            if (done_nxt) begin
                done_src <= cur_src;
            end
            if (grant) begin
                spi_data   <= grant_b ? b_hold : a_hold;
                cur_src    <= grant_b;
                last_grant <= grant_b;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: default timing instance plus a FRAME_CYCLES=1, GAP_CYCLES=0 instance.
module tb_spi_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [15:0] a_data, b_data, spi_data;
    logic        spi_write, busy, done, done_src;
    logic        a2_valid, a2_ready, b2_valid, b2_ready;
    logic [15:0] a2_data, b2_data, spi2_data;
    logic        spi2_write, busy2, done2, done2_src;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_tx_arbiter #(.WIDTH(16), .FRAME_CYCLES(18), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .spi_data(spi_data), .spi_write(spi_write), .busy(busy),
        .done(done), .done_src(done_src)
    );

    spi_tx_arbiter #(.WIDTH(16), .FRAME_CYCLES(1), .GAP_CYCLES(0)) dut_fast (
        .clk(clk), .reset(reset),
        .a_valid(a2_valid), .a_ready(a2_ready), .a_data(a2_data),
        .b_valid(b2_valid), .b_ready(b2_ready), .b_data(b2_data),
        .spi_data(spi2_data), .spi_write(spi2_write), .busy(busy2),
        .done(done2), .done_src(done2_src)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_valid = 0; b_valid = 0; a2_valid = 0; b2_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, b_ready, spi_write, busy, done, done_src} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 110000", {a_ready, b_ready, spi_write, busy, done, done_src});
        end
        n_checks++;
        if (spi_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_spi_data got %h want 0000", spi_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_launch();
        do_reset();
        a_data = 16'hA5C3; a_valid = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 1'b0;
            n_checks++;
            if (spi_write !== 1'(k == 2)) begin
                n_fail++; $display("FAIL single_spi_write k=%0d got %b", k, spi_write);
            end
            n_checks++;
            if (busy !== 1'(k >= 2 && k <= 21)) begin
                n_fail++; $display("FAIL single_busy k=%0d got %b", k, busy);
            end
            n_checks++;
            if (done !== 1'(k == 20)) begin
                n_fail++; $display("FAIL single_done k=%0d got %b", k, done);
            end
            n_checks++;
            if (a_ready !== 1'(k >= 3)) begin
                n_fail++; $display("FAIL single_a_ready k=%0d got %b", k, a_ready);
            end
            if (k == 2 || k == 23) begin
                n_checks++;
                if (spi_data !== 16'hA5C3) begin
                    n_fail++; $display("FAIL single_spi_data k=%0d got %h want a5c3", k, spi_data);
                end
            end
            if (k == 20) begin
                n_checks++;
                if (done_src !== 1'b0) begin
                    n_fail++; $display("FAIL single_done_src got %b want 0", done_src);
                end
            end
        end
    endtask

    task automatic test_same_edge();
        int          lk[$];
        logic [15:0] ld[$];
        int          dk[$];
        logic        ds[$];
        do_reset();
        a_data = 16'h1111; b_data = 16'h2222; a_valid = 1; b_valid = 1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) begin a_valid = 0; b_valid = 0; end
            if (spi_write) begin lk.push_back(k); ld.push_back(spi_data); end
            if (done) begin dk.push_back(k); ds.push_back(done_src); end
        end
        n_checks++;
        if (lk.size() != 2 || dk.size() != 2) begin
            n_fail++; $display("FAIL same_edge_counts launches %0d dones %0d want 2 2", lk.size(), dk.size());
        end else begin
            n_checks++;
            if (lk[0] != 2 || lk[1] != 23) begin
                n_fail++; $display("FAIL same_edge_spacing got %0d,%0d want 2,23", lk[0], lk[1]);
            end
            n_checks++;
            if (ld[0] !== 16'h1111 || ld[1] !== 16'h2222) begin
                n_fail++; $display("FAIL same_edge_order got %h,%h want 1111,2222", ld[0], ld[1]);
            end
            n_checks++;
            if (dk[0] != 20 || dk[1] != 41 || ds[0] !== 1'b0 || ds[1] !== 1'b1) begin
                n_fail++; $display("FAIL same_edge_done got k%0d/%b k%0d/%b want k20/0 k41/1", dk[0], ds[0], dk[1], ds[1]);
            end
        end
    endtask

    task automatic test_alternation();
        logic [15:0] got[$];
        logic [15:0] exp_w[6];
        logic        a_acc, b_acc;
        exp_w = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0102, 16'h0202};
        do_reset();
        a_data = 16'h0100; b_data = 16'h0200; a_valid = 1; b_valid = 1;
        a_acc = a_ready; b_acc = b_ready;
        for (int c = 0; c < 200 && got.size() < 6; c++) begin
            @(negedge clk);
            if (a_acc) a_data = a_data + 16'd1;
            if (b_acc) b_data = b_data + 16'd1;
            a_acc = a_ready; b_acc = b_ready;
            if (spi_write) got.push_back(spi_data);
        end
        a_valid = 0; b_valid = 0;
        n_checks++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL alt_count got %0d launches want 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            n_checks++;
            if (got[i] !== exp_w[i]) begin
                n_fail++; $display("FAIL alt_word%0d got %h want %h", i, got[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_b_during_frame();
        int          lk[$];
        logic [15:0] ld[$];
        int          dk[$];
        logic        ds[$];
        do_reset();
        a_data = 16'h3C3C; a_valid = 1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 0;
            if (k == 5) begin b_data = 16'hBEEF; b_valid = 1; end
            if (k == 6) begin
                n_checks++;
                if (b_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bdf_b_ready got %b want 0", b_ready);
                end
                b_valid = 0;
            end
            if (spi_write) begin lk.push_back(k); ld.push_back(spi_data); end
            if (done) begin dk.push_back(k); ds.push_back(done_src); end
        end
        n_checks++;
        if (lk.size() != 2 || dk.size() != 2) begin
            n_fail++; $display("FAIL bdf_counts launches %0d dones %0d want 2 2", lk.size(), dk.size());
        end else begin
            n_checks++;
            if (lk[0] != 2 || lk[1] != 23 || ld[0] !== 16'h3C3C || ld[1] !== 16'hBEEF) begin
                n_fail++; $display("FAIL bdf_launch got k%0d/%h k%0d/%h want k2/3c3c k23/beef", lk[0], ld[0], lk[1], ld[1]);
            end
            n_checks++;
            if (dk[1] != 41 || ds[1] !== 1'b1) begin
                n_fail++; $display("FAIL bdf_done got k%0d/%b want k41/1", dk[1], ds[1]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int stray;
        do_reset();
        a_data = 16'h4444; b_data = 16'h5555; a_valid = 1; b_valid = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin a_valid = 0; b_valid = 0; end
        end
        n_checks++;
        if (busy !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre busy %b b_ready %b want 1 0", busy, b_ready);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, b_ready, spi_write, busy, done, done_src} !== 6'b110000 || spi_data !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs got %b/%h want 110000/0000",
                               {a_ready, b_ready, spi_write, busy, done, done_src}, spi_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (spi_write || done) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL mid_stray got %0d strobes want 0", stray);
        end
        a_data = 16'h7777; a_valid = 1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 0;
        end
        n_checks++;
        if (spi_write !== 1'b1 || spi_data !== 16'h7777) begin
            n_fail++; $display("FAIL mid_relaunch got %b/%h want 1/7777", spi_write, spi_data);
        end
    endtask

    task automatic test_fast_config();
        logic        a_acc, b_acc;
        logic [15:0] exp_d;
        int          i;
        do_reset();
        a2_data = 16'h0A00; b2_data = 16'h0B00; a2_valid = 1; b2_valid = 1;
        a_acc = a2_ready; b_acc = b2_ready;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (a_acc) a2_data = a2_data + 16'd1;
            if (b_acc) b2_data = b2_data + 16'd1;
            a_acc = a2_ready; b_acc = b2_ready;
            n_checks++;
            if (spi2_write !== 1'(k >= 2 && k % 2 == 0)) begin
                n_fail++; $display("FAIL fast_write k=%0d got %b", k, spi2_write);
            end
            n_checks++;
            if (done2 !== 1'(k >= 3 && k % 2 == 1)) begin
                n_fail++; $display("FAIL fast_done k=%0d got %b", k, done2);
            end
            if (k >= 2 && k % 2 == 0) begin
                i = (k - 2) / 2;
                exp_d = ((i % 2) != 0) ? 16'h0B00 + 16'(i / 2) : 16'h0A00 + 16'(i / 2);
                n_checks++;
                if (spi2_data !== exp_d) begin
                    n_fail++; $display("FAIL fast_data k=%0d got %h want %h", k, spi2_data, exp_d);
                end
            end
            if (k >= 3 && k % 2 == 1) begin
                n_checks++;
                if (done2_src !== 1'(((k - 3) / 2) % 2)) begin
                    n_fail++; $display("FAIL fast_done_src k=%0d got %b", k, done2_src);
                end
            end
        end
        a2_valid = 0; b2_valid = 0;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
        a2_valid = 0; b2_valid = 0; a2_data = '0; b2_data = '0;
        test_reset();
        test_single_launch();
        test_same_edge();
        test_alternation();
        test_b_during_frame();
        test_reset_mid_frame();
        test_fast_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
